shift_seq_ctrl: RTL and testbench
=================================

Name: shift_seq_ctrl

Overview:
- Multi-cycle sequencer for RV32I shift instructions (SLL/SRL/SRA/SLLI/SRLI/SRAI) in the area-reduced ALU build.
- Instead of a 32-bit barrel shifter, it iterates a single-bit shift step once per cycle, up to 31 times.
- Sits beside the ALU, driven by the execute-stage control.
- Provides a start/busy/done handshake so the pipeline control can stall execute until the result is valid.

Parameters:
- XLEN, 32, datapath width in bits.
- SHW, 5, shift-amount width; must equal log2(XLEN).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a new shift; sampled on the rising edge.
- op  input  2  00 = SLL, 01 = SRL, 11 = SRA, 10 = reserved (executes as SLL).
- operand  input  XLEN  value to shift; captured when start is accepted.
- shamt  input  SHW  shift amount; captured when start is accepted.
- kill  input  1  pipeline flush; aborts any operation in flight.
- busy  output  1  high while a shift is in progress (state SHIFT).
- done  output  1  one-cycle pulse; result is valid in that cycle.
- result  output  XLEN  shifted value; held stable from done until the next accepted start.

Behaviour:
- Reset (asynchronous, active-high): state = IDLE, busy = 0, done = 0, result = 0, internal count = 0, internal op = SLL. Reset asserted mid-shift discards the operation; no done is produced.
- States:
  - IDLE: waiting for start.
  - SHIFT: one single-bit step per cycle.
  - DONE: one cycle, done = 1.
- Start acceptance:
  - Accepted when start = 1 and state is IDLE or DONE (DONE acceptance allows back-to-back shifts).
  - Ignored in SHIFT; busy = 1 tells the requester to hold start.
- On the accepting edge: data register <= operand, count <= shamt, op captured.
  - shamt = 0 -> next state DONE.
  - otherwise -> next state SHIFT.
- Each edge in SHIFT:
  - data <= one-bit step of data per captured op: SLL = {d[XLEN-2:0],0}; SRL = {0,d[XLEN-1:1]}; SRA = {d[XLEN-1],d[XLEN-1:1]}.
  - count <= count - 1.
  - When count == 1 on that edge, next state is DONE.
- Latency: done is high in the cycle after shamt+1 rising edges, counting the accepting edge. shamt = 0 -> 1 cycle; shamt = 31 -> 32 cycles.
- result is driven from the data register. It is architecturally valid only while done = 1 and holds afterward. In SHIFT it shows partial values that consumers must ignore.
- DONE -> IDLE on the next edge unless a new start is accepted (then SHIFT or DONE as above). done is never high for two consecutive cycles unless a back-to-back shamt = 0 start is accepted.
- kill:
  - Synchronous; highest priority after rst.
  - Forces IDLE on the next edge, suppresses done, and ignores a simultaneous start.
  - result keeps its last register value.
- Only shamt[SHW-1:0] is used; the count never wraps below zero.

Decomposition:
- Shared package (alu_defs): op encodings SH_SLL = 2'b00, SH_SRL = 2'b01, SH_SRA = 2'b11; state encodings IDLE/SHIFT/DONE; XLEN.
- One natural sub-module: shift_step. Purely combinational one-bit left/right/arithmetic-right step selected by op. It generalizes the existing left-by-one shifter and is instantiated once inside the sequencer.

Test Plan:
- SLL: operand 0x0000_0001, shamt 4, start for 1 cycle -> busy high 4 cycles, done pulse on cycle 5, result 0x0000_0010.
- SRA vs SRL: operand 0x8000_0000, shamt 31.
  - SRA -> result 0xFFFF_FFFF, done 32 cycles after start.
  - SRL -> result 0x0000_0001.
- shamt 0: operand 0xDEAD_BEEF, op SRA -> done next cycle, busy never asserted, result 0xDEAD_BEEF. Then start in the DONE cycle with SLL, shamt 8 -> accepted, result 0xADBE_EF00.
- Ignored start: start with new operands asserted while busy -> no effect on the in-flight result.
- kill: kill on cycle 3 of a shamt 10 shift -> IDLE next cycle, no done pulse. A subsequent start completes normally.
- Async reset: rst pulsed mid-shift between clock edges -> outputs go to 0 immediately and no done appears. After release, start op 10 (reserved), operand 0x3, shamt 1 -> result 0x6 (SLL behaviour).

Source files
------------

// File: rtl/shift_seq_ctrl_pkg.sv
// Shared definitions for the multi-cycle shift sequencer: datapath widths,
// shift-op encodings and FSM state encodings.
package shift_seq_ctrl_pkg;

  localparam int XLEN = 32;
  localparam int SHW  = 5;

  // 2'b10 is reserved and executes as SLL.
  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Request/response bundle between execute-stage control (master) and the
// shift sequencer (slave).
interface shift_seq_ctrl_if;
  import shift_seq_ctrl_pkg::*;

  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] operand;
  logic [SHW-1:0]  shamt;
  logic            kill;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, operand, shamt, kill,
    input  busy, done, result
  );

  modport slave (
    input  start, op, operand, shamt, kill,
    output busy, done, result
  );

endinterface

// File: rtl/shift_seq_ctrl_shift_step.sv
// One-bit shift step: left, logical right or arithmetic right, selected by op.
// Reserved op encodings fall back to a left shift.
module shift_seq_ctrl_shift_step
  import shift_seq_ctrl_pkg::*;
(
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] din,
  output logic [XLEN-1:0] dout
);

  // Select the single-bit step for the requested direction.
  always_comb begin
    dout = {din[XLEN-2:0], 1'b0};
    case (op)
      SH_SRL:  dout = {1'b0, din[XLEN-1:1]};
      SH_SRA:  dout = {din[XLEN-1], din[XLEN-1:1]};
      default: dout = {din[XLEN-2:0], 1'b0};
    endcase
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: replaces a barrel shifter by iterating a
// single-bit step once per cycle, with a start/busy/done handshake so the
// pipeline can stall execute until the result is valid.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | one single-bit step per cycle, count tracks steps remaining
// DONE  | result valid for exactly this cycle; a new start may be accepted
module shift_seq_ctrl
  import shift_seq_ctrl_pkg::*;
(
  input logic              clk,
  input logic              rst,
  shift_seq_ctrl_if.slave  bus
);

  state_t          state, state_next;
  logic [XLEN-1:0] data;
  logic [XLEN-1:0] data_step;
  logic [SHW-1:0]  count;
  logic [1:0]      op_q;
  logic            load;
  logic            step;

  shift_seq_ctrl_shift_step u_shift_step (
    .op   (op_q),
    .din  (data),
    .dout (data_step)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath control; kill overrides everything, including a
  // simultaneous start, and freezes the data register.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    if (bus.kill) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            load       = 1'b1;
            state_next = (bus.shamt == '0) ? DONE : SHIFT;
          end else begin
            state_next = IDLE;
          end
        end
        SHIFT: begin
          step = 1'b1;
          if (count == SHW'(1)) begin
            state_next = DONE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Data, remaining-count and captured-op registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      count <= '0;
      op_q  <= SH_SLL;
    end else if (load) begin
      data  <= bus.operand;
      count <= bus.shamt;
      op_q  <= bus.op;
    end else if (step) begin
      data <= data_step;
      if (count != '0) begin
        count <= count - SHW'(1);
      end
    end
  end

  // Outputs decode straight from state; result shows partial values in SHIFT.
  assign bus.busy   = (state == SHIFT);
  assign bus.done   = (state == DONE);
  assign bus.result = data;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed self-checking bench for the shift sequencer.
module tb_shift_seq_ctrl;

  logic clk;
  logic rst;
  int   tests;
  int   failed;
  int   lat;
  int   busy_cyc;
  int   done_seen;

  shift_seq_ctrl_if bus ();

  shift_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one start and wait (bounded) for done; reports cycles from the
  // accepting edge and the number of cycles busy was seen high.
  task automatic run_op(input logic [1:0] op, input logic [31:0] operand,
                        input logic [4:0] shamt, output int n, output int nb);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.operand = operand;
    bus.shamt   = shamt;
    tick();
    bus.start = 1'b0;
    n  = 1;
    nb = 0;
    while (bus.done !== 1'b1 && n < 100) begin
      if (bus.busy === 1'b1) nb++;
      tick();
      n++;
    end
  endtask

  initial begin
    tests       = 0;
    failed      = 0;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.operand = '0;
    bus.shamt   = '0;
    bus.kill    = 1'b0;
    tick();
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_result", bus.result, 32'd0);
    rst = 1'b0;
    tick();

    // SLL 1 by 4
    run_op(2'b00, 32'h0000_0001, 5'd4, lat, busy_cyc);
    check("sll4_latency", lat, 5);
    check("sll4_busy_cycles", busy_cyc, 4);
    check("sll4_result", bus.result, 32'h0000_0010);
    check("sll4_busy_in_done", {31'd0, bus.busy}, 32'd0);
    tick();
    check("sll4_done_one_cycle", {31'd0, bus.done}, 32'd0);
    check("sll4_result_held", bus.result, 32'h0000_0010);

    // SRA / SRL of the sign bit by 31
    run_op(2'b11, 32'h8000_0000, 5'd31, lat, busy_cyc);
    check("sra31_latency", lat, 32);
    check("sra31_result", bus.result, 32'hFFFF_FFFF);
    tick();
    run_op(2'b01, 32'h8000_0000, 5'd31, lat, busy_cyc);
    check("srl31_latency", lat, 32);
    check("srl31_result", bus.result, 32'h0000_0001);
    tick();

    // shamt 0, then back-to-back start in the DONE cycle
    run_op(2'b11, 32'hDEAD_BEEF, 5'd0, lat, busy_cyc);
    check("sh0_latency", lat, 1);
    check("sh0_busy_cycles", busy_cyc, 0);
    check("sh0_result", bus.result, 32'hDEAD_BEEF);
    run_op(2'b00, 32'hDEAD_BEEF, 5'd8, lat, busy_cyc);
    check("b2b_latency", lat, 9);
    check("b2b_result", bus.result, 32'hADBE_EF00);
    tick();

    // start while busy is ignored
    bus.start   = 1'b1;
    bus.op      = 2'b00;
    bus.operand = 32'h0000_0001;
    bus.shamt   = 5'd4;
    tick();
    bus.start = 1'b0;
    tick();
    bus.start   = 1'b1;
    bus.op      = 2'b01;
    bus.operand = 32'hFFFF_0000;
    bus.shamt   = 5'd2;
    tick();
    bus.start = 1'b0;
    check("ign_busy", {31'd0, bus.busy}, 32'd1);
    lat = 3;
    while (bus.done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    check("ign_latency", lat, 5);
    check("ign_result", bus.result, 32'h0000_0010);
    tick();
    check("ign_idle_after", {31'd0, bus.busy}, 32'd0);

    // kill on cycle 3 of a shamt 10 shift, with a simultaneous start
    bus.start   = 1'b1;
    bus.op      = 2'b00;
    bus.operand = 32'h0000_0001;
    bus.shamt   = 5'd10;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.kill    = 1'b1;
    bus.start   = 1'b1;
    bus.operand = 32'h1234_5678;
    bus.shamt   = 5'd0;
    tick();
    bus.kill  = 1'b0;
    bus.start = 1'b0;
    check("kill_busy", {31'd0, bus.busy}, 32'd0);
    check("kill_done", {31'd0, bus.done}, 32'd0);
    check("kill_result_frozen", bus.result, 32'h0000_0004);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
      tick();
    end
    check("kill_no_late_activity", done_seen, 0);
    run_op(2'b01, 32'h0000_0100, 5'd3, lat, busy_cyc);
    check("post_kill_latency", lat, 4);
    check("post_kill_result", bus.result, 32'h0000_0020);
    tick();

    // asynchronous reset between edges mid-shift
    bus.start   = 1'b1;
    bus.op      = 2'b00;
    bus.operand = 32'h0000_00FF;
    bus.shamt   = 5'd10;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_done", {31'd0, bus.done}, 32'd0);
    check("arst_result", bus.result, 32'd0);
    #1;
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done === 1'b1) done_seen++;
    end
    check("arst_no_done", done_seen, 0);
    run_op(2'b10, 32'h0000_0003, 5'd1, lat, busy_cyc);
    check("reserved_latency", lat, 2);
    check("reserved_result", bus.result, 32'h0000_0006);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
